sdram_memtest: RTL and testbench

//  Self-checking traffic generator that drives the SDRAM controller system bus (bus_req_*/bus_rsp_*).

---
 rtl/sdram_memtest_pkg.sv | 43 ++++
 rtl/memtest_lfsr.sv | 22 ++
 rtl/sdram_memtest.sv | 239 +++++++++++++++++++++++
 tb/tb_sdram_memtest.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_memtest_pkg.sv
// Shared types and pattern helpers for the SDRAM memory test traffic generator.
package sdram_memtest_pkg;

    localparam int unsigned LFSR_W = 16;

    // Feedback mask for the right-shifting Fibonacci LFSR: bits 0,2,3,5
    // correspond to polynomial taps 16,14,13,11.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        PAT_ADDR  = 2'd0,
        PAT_LFSR  = 2'd1,
        PAT_NADDR = 2'd2,
        PAT_CHECK = 2'd3
    } pattern_t;

    // One LFSR step: feedback enters at the MSB, state shifts right.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
    endfunction

    // Data word for a given pattern, address (low 16 bits) and LFSR state.
    function automatic logic [15:0] pattern_data(input pattern_t p,
                                                 input logic [15:0] a,
                                                 input logic [LFSR_W-1:0] lfsr);
        logic [15:0] d;
        case (p)
            PAT_ADDR:  d = a;
            PAT_LFSR:  d = lfsr;
            PAT_NADDR: d = ~a;
            default:   d = a[0] ? 16'h5555 : 16'hAAAA;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/memtest_lfsr.sv
// 16-bit pattern LFSR with synchronous seed load and step enable.
module memtest_lfsr
    import sdram_memtest_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                en,
    input  logic [LFSR_W-1:0]   seed,
    output logic [LFSR_W-1:0]   value
);

    // Reseed on reset or run start; otherwise step once per enabled cycle.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            value <= seed;
        end else if (en) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/sdram_memtest.sv
// SDRAM bus traffic generator: fills a word range with a pattern, reads it
// back with several reads in flight, and reports mismatches.
module sdram_memtest
    import sdram_memtest_pkg::*;
#(
    parameter int unsigned   AW         = 23,
    parameter int unsigned   DW         = 16,
    parameter logic [AW-1:0] START_ADDR = '0,
    parameter logic [AW-1:0] END_ADDR   = '1,
    parameter int unsigned   MAX_OUT    = 4,
    parameter logic [15:0]   LFSR_SEED  = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    pattern,
    output logic          bus_req_read,
    output logic          bus_req_write,
    output logic [AW-1:0] bus_req_addr,
    output logic [DW-1:0] bus_req_wdata,
    input  logic          bus_req_ready,
    input  logic          bus_rsp_valid,
    input  logic [DW-1:0] bus_rsp_rdata,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [15:0]   err_count,
    output logic [AW-1:0] first_err_addr,
    output logic [DW-1:0] first_err_exp,
    output logic [DW-1:0] first_err_act,
    output logic          proto_err
);

    localparam int unsigned OW = 4;
    localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);

    state_t        state;
    state_t        state_nx;
    pattern_t      pat;
    pattern_t      pat_d;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] outstanding_d;
    logic          issue_left;
    logic          issue_left_d;
    logic [AW-1:0] chk_addr;
    logic [AW-1:0] chk_addr_d;
    logic [15:0]   wr_lfsr;
    logic [15:0]   chk_lfsr;

    logic          read_d;
    logic          write_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;
    logic          busy_d;
    logic          done_d;
    logic          pass_d;
    logic [15:0]   err_count_d;
    logic [AW-1:0] fe_addr_d;
    logic [DW-1:0] fe_exp_d;
    logic [DW-1:0] fe_act_d;
    logic          proto_err_d;

    logic          start_go;
    logic          wr_xfer;
    logic          rd_xfer;
    logic          rsp_ok;
    logic          rsp_bad;
    logic          last_addr;
    logic [AW-1:0] next_addr;
    logic [DW-1:0] exp_c;
    logic          mismatch;

    // Handshake and compare qualifiers derived from current registered state.
    assign start_go  = start && ((state == IDLE) || (state == DONE));
    assign wr_xfer   = bus_req_write && bus_req_ready;
    assign rd_xfer   = bus_req_read && bus_req_ready;
    assign rsp_ok    = bus_rsp_valid && (outstanding != '0);
    assign rsp_bad   = bus_rsp_valid && (outstanding == '0);
    assign last_addr = (bus_req_addr == END_ADDR);
    assign next_addr = bus_req_addr + AW'(1);
    assign exp_c     = DW'(pattern_data(pat, 16'(chk_addr), chk_lfsr));
    assign mismatch  = rsp_ok && (bus_rsp_rdata != exp_c);

    // Write-side generator advances once per accepted write.
    memtest_lfsr u_wr_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (start_go),
        .en    (wr_xfer),
        .seed  (LFSR_SEED),
        .value (wr_lfsr)
    );

    // Check-side generator replays the same stream once per counted response.
    memtest_lfsr u_chk_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (start_go),
        .en    (rsp_ok),
        .seed  (LFSR_SEED),
        .value (chk_lfsr)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = WRITE;
            WRITE:      if (wr_xfer && last_addr) state_nx = READ;
            READ:       if (!issue_left && (outstanding == '0)) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    // Next values for the bus request, counters and status registers.
    always_comb begin
        addr_d        = bus_req_addr;
        wdata_d       = bus_req_wdata;
        issue_left_d  = issue_left;
        outstanding_d = outstanding;
        chk_addr_d    = chk_addr;
        pat_d         = pat;
        err_count_d   = err_count;
        fe_addr_d     = first_err_addr;
        fe_exp_d      = first_err_exp;
        fe_act_d      = first_err_act;
        proto_err_d   = proto_err;

        if (start_go) begin
            pat_d        = pattern_t'(pattern);
            addr_d       = START_ADDR;
            wdata_d      = DW'(pattern_data(pattern_t'(pattern), 16'(START_ADDR), LFSR_SEED));
            issue_left_d = 1'b0;
            chk_addr_d   = START_ADDR;
            err_count_d  = '0;
            fe_addr_d    = '0;
            fe_exp_d     = '0;
            fe_act_d     = '0;
            proto_err_d  = 1'b0;
        end

        if (wr_xfer) begin
            if (last_addr) begin
                addr_d       = START_ADDR;
                issue_left_d = 1'b1;
            end else begin
                addr_d  = next_addr;
                wdata_d = DW'(pattern_data(pat, 16'(next_addr), lfsr_next(wr_lfsr)));
            end
        end

        if (rd_xfer) begin
            outstanding_d = outstanding_d + OW'(1);
            if (last_addr) begin
                issue_left_d = 1'b0;
            end else begin
                addr_d = next_addr;
            end
        end

        if (rsp_ok) begin
            outstanding_d = outstanding_d - OW'(1);
            if (chk_addr != END_ADDR) begin
                chk_addr_d = chk_addr + AW'(1);
            end
            if (mismatch) begin
                if (err_count != 16'hFFFF) begin
                    err_count_d = err_count + 16'd1;
                end
                if (err_count == '0) begin
                    fe_addr_d = chk_addr;
                    fe_exp_d  = exp_c;
                    fe_act_d  = bus_rsp_rdata;
                end
            end
        end

        if (rsp_bad) begin
            proto_err_d = 1'b1;
        end

        // Requests follow the next state so they appear one cycle after start
        // and drop the moment the final transfer completes.
        write_d = (state_nx == WRITE);
        read_d  = (state_nx == READ) && issue_left_d && (outstanding_d < MAX_OUT_C);
        busy_d  = (state_nx == WRITE) || (state_nx == READ);
        done_d  = (state_nx == DONE);
        pass_d  = done_d && (err_count_d == '0) && !proto_err_d;
    end

    // Registered outputs and datapath state.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req_read   <= 1'b0;
            bus_req_write  <= 1'b0;
            bus_req_addr   <= '0;
            bus_req_wdata  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_act  <= '0;
            proto_err      <= 1'b0;
            pat            <= PAT_ADDR;
            outstanding    <= '0;
            issue_left     <= 1'b0;
            chk_addr       <= '0;
        end else begin
            bus_req_read   <= read_d;
            bus_req_write  <= write_d;
            bus_req_addr   <= addr_d;
            bus_req_wdata  <= wdata_d;
            busy           <= busy_d;
            done           <= done_d;
            pass           <= pass_d;
            err_count      <= err_count_d;
            first_err_addr <= fe_addr_d;
            first_err_exp  <= fe_exp_d;
            first_err_act  <= fe_act_d;
            proto_err      <= proto_err_d;
            pat            <= pat_d;
            outstanding    <= outstanding_d;
            issue_left     <= issue_left_d;
            chk_addr       <= chk_addr_d;
        end
    end

endmodule

// File: tb/tb_sdram_memtest.sv
// Bench for sdram_memtest: four instances with different address ranges share
// one behavioural SDRAM controller model, selected per test.
module tb_sdram_memtest;

    localparam int unsigned AW   = 9;
    localparam int unsigned NDUT = 4;
    localparam int unsigned ST [NDUT] = '{0, 100, 0, 5};
    localparam int unsigned EN [NDUT] = '{15, 355, 3, 5};

    typedef struct { logic [AW-1:0] addr; logic [15:0] data; } wr_t;
    typedef struct { logic [AW-1:0] addr; int due; } pend_t;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        start     = 1'b0;
    logic [1:0]  pattern   = 2'd0;
    logic        ready     = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [15:0] rdata     = 16'h0;
    logic [1:0]  sel       = 2'd0;

    logic          start_v     [NDUT];
    logic          ready_v     [NDUT];
    logic          rsp_valid_v [NDUT];
    logic          req_read_v  [NDUT];
    logic          req_write_v [NDUT];
    logic [AW-1:0] req_addr_v  [NDUT];
    logic [15:0]   req_wdata_v [NDUT];
    logic          busy_v      [NDUT];
    logic          done_v      [NDUT];
    logic          pass_v      [NDUT];
    logic [15:0]   err_v       [NDUT];
    logic [AW-1:0] fe_addr_v   [NDUT];
    logic [15:0]   fe_exp_v    [NDUT];
    logic [15:0]   fe_act_v    [NDUT];
    logic          proto_v     [NDUT];

    logic          m_read, m_write, m_busy, m_done, m_pass, m_proto;
    logic [AW-1:0] m_addr, m_fe_addr;
    logic [15:0]   m_wdata, m_err, m_fe_exp, m_fe_act;

    int checks = 0;
    int errors = 0;

    // Model state.
    logic [15:0]   mem [512];
    wr_t           exp_wr_q [$];
    logic [AW-1:0] exp_rd_q [$];
    pend_t         pend [$];
    pend_t         p;
    wr_t           e;
    logic [15:0]   rd;
    int            cyc = 0;
    int            last_due = 0;
    int            due;
    int            outst = 0;
    int            max_seen = 0;
    int            nwr = 0;
    int            both_high = 0;
    int            ready_pct = 100;
    int            corrupt_addr = -1;
    bit            zero_mode = 1'b0;
    bit            inject = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        assign start_v[g]     = start && (sel == 2'(g));
        assign ready_v[g]     = ready && (sel == 2'(g));
        assign rsp_valid_v[g] = rsp_valid && (sel == 2'(g));

        sdram_memtest #(
            .AW         (AW),
            .DW         (16),
            .START_ADDR (AW'(ST[g])),
            .END_ADDR   (AW'(EN[g])),
            .MAX_OUT    (4),
            .LFSR_SEED  (16'hACE1)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .start          (start_v[g]),
            .pattern        (pattern),
            .bus_req_read   (req_read_v[g]),
            .bus_req_write  (req_write_v[g]),
            .bus_req_addr   (req_addr_v[g]),
            .bus_req_wdata  (req_wdata_v[g]),
            .bus_req_ready  (ready_v[g]),
            .bus_rsp_valid  (rsp_valid_v[g]),
            .bus_rsp_rdata  (rdata),
            .busy           (busy_v[g]),
            .done           (done_v[g]),
            .pass           (pass_v[g]),
            .err_count      (err_v[g]),
            .first_err_addr (fe_addr_v[g]),
            .first_err_exp  (fe_exp_v[g]),
            .first_err_act  (fe_act_v[g]),
            .proto_err      (proto_v[g])
        );
    end

    // Outputs of the instance currently under test.
    always_comb begin
        m_read    = req_read_v[sel];
        m_write   = req_write_v[sel];
        m_addr    = req_addr_v[sel];
        m_wdata   = req_wdata_v[sel];
        m_busy    = busy_v[sel];
        m_done    = done_v[sel];
        m_pass    = pass_v[sel];
        m_err     = err_v[sel];
        m_fe_addr = fe_addr_v[sel];
        m_fe_exp  = fe_exp_v[sel];
        m_fe_act  = fe_act_v[sel];
        m_proto   = proto_v[sel];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic logic [15:0] exp_data(input logic [1:0] pat, input logic [AW-1:0] a,
                                             input logic [15:0] l);
        case (pat)
            2'd0:    return 16'(a);
            2'd1:    return l;
            2'd2:    return ~16'(a);
            default: return a[0] ? 16'h5555 : 16'hAAAA;
        endcase
    endfunction

    // Controller model: drives ready/response on the falling edge, scoreboards
    // the requests that will transfer on the next rising edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            pend.delete();
            ready     = 1'b0;
            rsp_valid = 1'b0;
            outst     = 0;
            last_due  = 0;
        end else begin
            ready     = ($urandom_range(99) < 32'(ready_pct));
            rsp_valid = 1'b0;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                p  = pend.pop_front();
                rd = zero_mode ? 16'h0000 : mem[p.addr];
                if (int'(p.addr) == corrupt_addr) rd = rd ^ 16'h0010;
                rsp_valid = 1'b1;
                rdata     = rd;
                outst     = outst - 1;
            end else if (inject) begin
                rsp_valid = 1'b1;
                rdata     = 16'h0BAD;
                inject    = 1'b0;
            end
            if (m_read && m_write) both_high = both_high + 1;
            if (m_write && ready) begin
                if (exp_wr_q.size() == 0) begin
                    check("wr_extra", 32'(1), 32'(0));
                end else begin
                    e = exp_wr_q.pop_front();
                    check("wr_addr", 32'(m_addr), 32'(e.addr));
                    check("wr_data", 32'(m_wdata), 32'(e.data));
                end
                mem[m_addr] = m_wdata;
                nwr = nwr + 1;
            end
            if (m_read && ready) begin
                if (exp_rd_q.size() == 0) check("rd_extra", 32'(1), 32'(0));
                else check("rd_addr", 32'(m_addr), 32'(exp_rd_q.pop_front()));
                due = cyc + int'($urandom_range(8, 3));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                p.addr = m_addr;
                p.due  = due;
                pend.push_back(p);
                outst = outst + 1;
                if (outst > max_seen) max_seen = outst;
            end
        end
    end

    // Load the expected write stream and read address order for one run.
    task automatic prime(input logic [1:0] s, input logic [1:0] pat);
        logic [15:0] l;
        wr_t w;
        exp_wr_q.delete();
        exp_rd_q.delete();
        nwr = 0;
        max_seen = 0;
        both_high = 0;
        l = 16'hACE1;
        for (int a = int'(ST[s]); a <= int'(EN[s]); a++) begin
            w.addr = AW'(a);
            w.data = exp_data(pat, AW'(a), l);
            exp_wr_q.push_back(w);
            exp_rd_q.push_back(AW'(a));
            l = lfsr_step(l);
        end
    endtask

    task automatic run(input logic [1:0] s, input logic [1:0] pat, input int rpct, input bit poke);
        bit seen;
        int n;
        sel = s;
        pattern = pat;
        ready_pct = rpct;
        n = int'(EN[s]) - int'(ST[s]) + 1;
        prime(s, pat);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("first_write", 32'(m_write), 32'(1));
        check("first_addr", 32'(m_addr), ST[s]);
        check("busy", 32'(m_busy), 32'(1));
        seen = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            if (m_done) begin
                seen = 1'b1;
                break;
            end
            start = (poke && i == 20);
            @(negedge clk);
        end
        start = 1'b0;
        check("done_timeout", 32'(seen), 32'(1));
        check("wr_count", 32'(nwr), 32'(n));
        check("wr_left", 32'(exp_wr_q.size()), 32'(0));
        check("rd_left", 32'(exp_rd_q.size()), 32'(0));
        check("rw_both", 32'(both_high), 32'(0));
        check("max_out", 32'(max_seen <= 4), 32'(1));
        check("busy_end", 32'(m_busy), 32'(0));
    endtask

    initial begin
        bit seen;
        repeat (3) @(negedge clk);
        check("rst_read", 32'(m_read), 32'(0));
        check("rst_write", 32'(m_write), 32'(0));
        check("rst_busy", 32'(m_busy), 32'(0));
        check("rst_done", 32'(m_done), 32'(0));
        check("rst_pass", 32'(m_pass), 32'(0));
        check("rst_err", 32'(m_err), 32'(0));
        check("rst_proto", 32'(m_proto), 32'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Address pattern, full-rate ready.
        run(2'd0, 2'd0, 100, 1'b0);
        check("t1_done", 32'(m_done), 32'(1));
        check("t1_pass", 32'(m_pass), 32'(1));
        check("t1_err", 32'(m_err), 32'(0));

        // Stray response after completion, then a clean rerun.
        inject = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_proto", 32'(m_proto), 32'(1));
        check("t5_pass", 32'(m_pass), 32'(0));
        check("t5_done", 32'(m_done), 32'(1));
        run(2'd0, 2'd0, 100, 1'b0);
        check("t5_proto_clr", 32'(m_proto), 32'(0));
        check("t5_pass_again", 32'(m_pass), 32'(1));

        // LFSR pattern, random stalls, start pulse while busy.
        run(2'd1, 2'd1, 50, 1'b1);
        check("t2_pass", 32'(m_pass), 32'(1));
        check("t2_err", 32'(m_err), 32'(0));

        // Checkerboard with one corrupted read.
        corrupt_addr = 7;
        run(2'd0, 2'd3, 70, 1'b0);
        corrupt_addr = -1;
        check("t3_err", 32'(m_err), 32'(1));
        check("t3_fe_addr", 32'(m_fe_addr), 32'(7));
        check("t3_fe_exp", 32'(m_fe_exp), 32'h5555);
        check("t3_fe_act", 32'(m_fe_act), 32'h5545);
        check("t3_pass", 32'(m_pass), 32'(0));

        // Inverted address pattern against a memory that reads zero.
        zero_mode = 1'b1;
        run(2'd2, 2'd2, 100, 1'b0);
        zero_mode = 1'b0;
        check("t4_err", 32'(m_err), 32'(4));
        check("t4_fe_addr", 32'(m_fe_addr), 32'(0));
        check("t4_fe_exp", 32'(m_fe_exp), 32'hFFFF);
        check("t4_fe_act", 32'(m_fe_act), 32'h0000);
        check("t4_pass", 32'(m_pass), 32'(0));

        // Reset in the middle of the read phase.
        sel = 2'd0;
        pattern = 2'd0;
        ready_pct = 100;
        prime(2'd0, 2'd0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_read) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t6_read_seen", 32'(seen), 32'(1));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_read", 32'(m_read), 32'(0));
        check("t6_write", 32'(m_write), 32'(0));
        check("t6_addr", 32'(m_addr), 32'(0));
        check("t6_busy", 32'(m_busy), 32'(0));
        check("t6_done", 32'(m_done), 32'(0));
        check("t6_err", 32'(m_err), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        exp_wr_q.delete();
        exp_rd_q.delete();
        repeat (3) @(negedge clk);
        check("t6_idle_read", 32'(m_read), 32'(0));
        check("t6_idle_busy", 32'(m_busy), 32'(0));

        // Single-word range.
        run(2'd3, 2'd1, 60, 1'b0);
        check("t6_one_pass", 32'(m_pass), 32'(1));
        check("t6_one_err", 32'(m_err), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
